// File: rtl/div_ratio_detector.sv
// Measures the period and high time of a divided clock in clk cycles.
// Ports: clk, rst (sync active-low), clk_in in; period, high_cnt, valid,
// duty50, locked, overflow out. See body for state machine behaviour.
module div_ratio_detector #(
    parameter int W = 7
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         clk_in,
    output logic [W-1:0] period,
    output logic [W-1:0] high_cnt,
    output logic         valid,
    output logic         duty50,
    output logic         locked,
    output logic         overflow
);

    typedef enum logic [1:0] {
        IDLE,
        ARMED,
        MEASURE
    } state_t;

    localparam logic [W-1:0] CNT_MAX = {W{1'b1}};
    localparam logic [W-1:0] ONE     = {{(W-1){1'b0}}, 1'b1};
    localparam logic [W:0]   ONE_X   = {{W{1'b0}}, 1'b1};

    state_t state;
    state_t state_nx;

    logic s;
    logic s_d;
    // s holds its reset value (not a real sample) in the first cycle
    // after reset; primed keeps IDLE from arming on that stale zero so
    // a clk_in already high at release never produces a false rise.
    logic primed;
    logic rise;
    logic fall;

    logic [W-1:0] cnt;
    logic [W-1:0] cnt_nx;
    logic [W-1:0] hi;
    logic [W-1:0] hi_nx;
    logic [W-1:0] prev;
    logic [W-1:0] prev_nx;
    logic         seen;
    logic         seen_nx;

    logic [W-1:0] period_nx;
    logic [W-1:0] high_nx;
    logic         valid_nx;
    logic         duty_nx;
    logic         locked_nx;
    logic         ovf_nx;

    logic [W:0] twice;
    logic [W:0] cnt_x;
    logic       duty_hit;

    assign rise = s & ~s_d;
    assign fall = ~s & s_d;

    // 2*hi within one cycle of cnt, one bit wider so nothing wraps.
    assign twice    = {hi, 1'b0};
    assign cnt_x    = {1'b0, cnt};
    assign duty_hit = (twice == cnt_x)
                    | (twice == cnt_x + ONE_X)
                    | (twice + ONE_X == cnt_x);

    always_ff @(posedge clk) begin
        if (!rst) begin
            state    <= IDLE;
            s        <= 1'b0;
            s_d      <= 1'b0;
            primed   <= 1'b0;
            cnt      <= '0;
            hi       <= '0;
            prev     <= '0;
            seen     <= 1'b0;
            period   <= '0;
            high_cnt <= '0;
            valid    <= 1'b0;
            duty50   <= 1'b0;
            locked   <= 1'b0;
            overflow <= 1'b0;
        end else begin
            state    <= state_nx;
            s        <= clk_in;
            s_d      <= s;
            primed   <= 1'b1;
            cnt      <= cnt_nx;
            hi       <= hi_nx;
            prev     <= prev_nx;
            seen     <= seen_nx;
            period   <= period_nx;
            high_cnt <= high_nx;
            valid    <= valid_nx;
            duty50   <= duty_nx;
            locked   <= locked_nx;
            overflow <= ovf_nx;
        end
    end

    always_comb begin
        state_nx  = state;
        cnt_nx    = cnt;
        hi_nx     = hi;
        prev_nx   = prev;
        seen_nx   = seen;
        period_nx = period;
        high_nx   = high_cnt;
        valid_nx  = 1'b0;
        duty_nx   = duty50;
        locked_nx = locked;
        ovf_nx    = overflow;
        unique case (state)
            IDLE: begin
                if (primed && !s) begin
                    state_nx = ARMED;
                end
            end
            ARMED: begin
                if (rise) begin
                    state_nx = MEASURE;
                    cnt_nx   = ONE;
                    seen_nx  = 1'b0;
                end
            end
            MEASURE: begin
                if (rise) begin
                    period_nx = cnt;
                    high_nx   = hi;
                    valid_nx  = 1'b1;
                    duty_nx   = duty_hit;
                    locked_nx = seen && (cnt == prev);
                    prev_nx   = cnt;
                    seen_nx   = 1'b1;
                    cnt_nx    = ONE;
                end else if (cnt == CNT_MAX) begin
                    // Period too long to represent: drop it and rearm.
                    ovf_nx    = 1'b1;
                    locked_nx = 1'b0;
                    state_nx  = IDLE;
                end else begin
                    cnt_nx = cnt + ONE;
                    if (fall) begin
                        hi_nx = cnt;
                    end
                end
            end
            default: begin
                state_nx = IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_div_ratio_detector.sv
// Bench for div_ratio_detector: random divided clocks against a
// timestamp-based reference model, plus directed edge-case checks.
module tb_div_ratio_detector;

    localparam int W    = 7;
    localparam int MAXC = (1 << W) - 1;

    logic         clk    = 1'b0;
    logic         rst    = 1'b0;
    logic         clk_in = 1'b0;
    logic [W-1:0] period;
    logic [W-1:0] high_cnt;
    logic         valid;
    logic         duty50;
    logic         locked;
    logic         overflow;

    div_ratio_detector #(.W(W)) dut (
        .clk      (clk),
        .rst      (rst),
        .clk_in   (clk_in),
        .period   (period),
        .high_cnt (high_cnt),
        .valid    (valid),
        .duty50   (duty50),
        .locked   (locked),
        .overflow (overflow)
    );

    always #5 clk = ~clk;

    int n_chk = 0;
    int n_ok  = 0;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_ok++;
        else $display("FAIL %s: got %0h want %0h at %0t",
                      tag, got, exp, $time);
    endtask

    // Reference model, in terms of sample timestamps.
    bit run = 0;
    int idx;
    bit last_x;
    bit pend_x;
    bit pend_ok;
    int rise_t;
    int fall_t;
    int idle_start;
    int prev_n;
    bit have_prev;
    int m_period;
    int m_high;
    bit m_valid;
    bit m_duty;
    bit m_locked;
    bit m_ovf;

    task automatic m_reset();
        idx        = 0;
        last_x     = 0;
        pend_x     = 0;
        pend_ok    = 0;
        rise_t     = -1;
        fall_t     = 0;
        idle_start = 1;
        prev_n     = 0;
        have_prev  = 0;
        m_period   = 0;
        m_high     = 0;
        m_valid    = 0;
        m_duty     = 0;
        m_locked   = 0;
        m_ovf      = 0;
    endtask

    task automatic m_sample(input bit x);
        bit r;
        bit f;
        int n;
        int h;
        m_valid = 0;
        r = x && !last_x;
        f = !x && last_x;
        if (rise_t >= 0) begin
            if (r) begin
                n         = idx - rise_t;
                h         = fall_t - rise_t;
                m_period  = n;
                m_high    = h;
                m_valid   = 1;
                m_duty    = (2 * h >= n - 1) && (2 * h <= n + 1);
                m_locked  = have_prev && (n == prev_n);
                prev_n    = n;
                have_prev = 1;
                rise_t    = idx;
            end else if (idx - rise_t == MAXC) begin
                m_ovf      = 1;
                m_locked   = 0;
                rise_t     = -1;
                idle_start = idx + 1;
            end else if (f) begin
                fall_t = idx;
            end
        end else if (r && idx - 1 >= idle_start) begin
            rise_t    = idx;
            have_prev = 0;
        end
        last_x = x;
    endtask

    // Outputs after edge k reflect samples taken up to edge k-1.
    initial forever begin
        @(posedge clk);
        if (!rst) begin
            m_reset();
            run = 1;
        end else if (run) begin
            if (pend_ok) m_sample(pend_x);
            idx     = idx + 1;
            pend_x  = clk_in;
            pend_ok = 1;
        end
    end

    initial forever begin
        @(negedge clk);
        if (run) begin
            chk("valid", {31'd0, valid}, {31'd0, m_valid});
            chk("outs",
                {15'd0, period, high_cnt, duty50, locked, overflow},
                {15'd0, m_period[W-1:0], m_high[W-1:0],
                 m_duty, m_locked, m_ovf});
        end
    end

    task automatic cyc(input bit v, input int n);
        repeat (n) begin
            @(negedge clk);
            clk_in = v;
        end
    endtask

    task automatic wave(input int p, input int hmin, input int hmax,
                        input int n);
        repeat (n) begin
            int h;
            h = $urandom_range(hmax, hmin);
            cyc(1, h);
            cyc(0, p - h);
        end
    endtask

    task automatic do_rst(input bit lvl, input int n);
        @(negedge clk);
        rst    = 0;
        clk_in = lvl;
        repeat (n) @(negedge clk);
        rst = 1;
    endtask

    initial begin
        do_rst(0, 3);
        chk("rst_outs",
            {14'd0, period, high_cnt, valid, duty50, locked, overflow}, 0);

        cyc(0, 2);
        wave(9, 4, 5, 6);
        cyc(1, 3);
        chk("d9_period", period, 9);
        chk("d9_locked", locked, 1);
        chk("d9_duty", duty50, 1);
        chk("d9_ovf", overflow, 0);

        cyc(0, 2);
        wave(12, 3, 3, 5);
        cyc(1, 3);
        chk("d12_period", period, 12);
        chk("d12_high", high_cnt, 3);
        chk("d12_duty", duty50, 0);
        chk("d12_locked", locked, 1);

        cyc(0, 2);
        wave(80, 30, 50, 3);
        cyc(1, 3);
        chk("d80_period", period, 80);
        chk("d80_locked", locked, 1);

        cyc(0, 2);
        wave(9, 4, 5, 4);
        cyc(1, 3);
        chk("d9b_locked", locked, 1);
        cyc(0, 200);
        chk("ovf_set", overflow, 1);
        chk("ovf_unlock", locked, 0);
        chk("ovf_hold", period, 9);

        wave(9, 4, 5, 4);
        cyc(1, 3);
        chk("ovf_resume_p", period, 9);
        chk("ovf_sticky", overflow, 1);

        do_rst(0, 2);
        cyc(0, 2);
        wave(127, 60, 60, 3);
        cyc(1, 3);
        chk("p127_period", period, 127);
        chk("p127_high", high_cnt, 60);
        chk("p127_ovf", overflow, 0);

        cyc(0, 2);
        wave(9, 4, 4, 3);
        cyc(1, 4);
        cyc(0, 1);
        do_rst(0, 1);
        chk("mid_rst",
            {14'd0, period, high_cnt, valid, duty50, locked, overflow}, 0);
        cyc(0, 3);
        wave(9, 4, 5, 3);
        cyc(1, 3);
        chk("mid_rst_p", period, 9);

        do_rst(1, 2);
        cyc(1, 3);
        cyc(0, 4);
        wave(9, 5, 5, 1);
        cyc(1, 3);
        chk("hi_rel_p", period, 9);
        chk("hi_rel_lk", locked, 0);

        repeat (25) begin
            int p;
            int h;
            int n;
            p = $urandom_range(140, 2);
            h = $urandom_range(p - 1, 1);
            n = $urandom_range(4, 1);
            if ($urandom_range(7, 0) == 0)
                do_rst(1'($urandom_range(1, 0)), $urandom_range(3, 1));
            wave(p, h, h, n);
        end
        cyc(1, 3);
        cyc(0, 3);

        $display("%0d/%0d checks passed", n_ok, n_chk);
        $finish;
    end

endmodule
